// File: rtl/i2c_cfg_pkg.sv
// Shared types and constants for the I2C codec configuration sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: sequencer state enum, 16-bit table entry type, WM8731 register
// addresses, default table length and an entry-packing helper.
package i2c_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        REQ,
        XFER,
        CHECK,
        SETTLE,
        DONE,
        FAIL
    } cfg_state_t;

    // {sub_addr[7:0], data[7:0]}; for the WM8731 that is {reg[6:0], val[8:0]}
    typedef logic [15:0] cfg_entry_t;

    localparam logic [6:0] WM_LLINE_IN  = 7'h00;
    localparam logic [6:0] WM_RLINE_IN  = 7'h01;
    localparam logic [6:0] WM_LHP_OUT   = 7'h02;
    localparam logic [6:0] WM_RHP_OUT   = 7'h03;
    localparam logic [6:0] WM_ANA_PATH  = 7'h04;
    localparam logic [6:0] WM_DIG_PATH  = 7'h05;
    localparam logic [6:0] WM_PWR_DOWN  = 7'h06;
    localparam logic [6:0] WM_DIG_FMT   = 7'h07;
    localparam logic [6:0] WM_SAMPLING  = 7'h08;
    localparam logic [6:0] WM_ACTIVE    = 7'h09;
    localparam logic [6:0] WM_RESET     = 7'h0F;

    localparam int DEF_LUT_SIZE = 11;

    // The codec packs a 7-bit register address and a 9-bit value into 16 bits
    function automatic cfg_entry_t wm_entry(input logic [6:0] addr, input logic [8:0] val);
        return {addr, val};
    endfunction

endpackage

// File: rtl/i2c_cfg_rom.sv
// WM8731 register-init table: index -> {sub_addr, data}.
// Latency: combinational.
// Backpressure: none; indices past the table read as zero.
//
// Ports: index (6-bit table index), entry (16-bit table word).
module i2c_cfg_rom
    import i2c_cfg_pkg::*;
(
    input  logic [5:0]  index,
    output cfg_entry_t  entry
);

    always_comb begin
        entry = '0;
        case (index)
            6'd0:    entry = wm_entry(WM_RESET,    9'h000);
            6'd1:    entry = wm_entry(WM_LLINE_IN, 9'h017);
            6'd2:    entry = wm_entry(WM_RLINE_IN, 9'h017);
            6'd3:    entry = wm_entry(WM_LHP_OUT,  9'h079);
            6'd4:    entry = wm_entry(WM_RHP_OUT,  9'h079);
            6'd5:    entry = wm_entry(WM_ANA_PATH, 9'h012);
            6'd6:    entry = wm_entry(WM_DIG_PATH, 9'h000);
            6'd7:    entry = wm_entry(WM_PWR_DOWN, 9'h000);
            6'd8:    entry = wm_entry(WM_DIG_FMT,  9'h001);
            6'd9:    entry = wm_entry(WM_SAMPLING, 9'h000);
            6'd10:   entry = wm_entry(WM_ACTIVE,   9'h001);
            default: entry = '0;
        endcase
    end

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Walks the codec init table, issuing one I2C write per entry and checking ACK.
// Latency: LOAD->GO 1 cycle; status updates 1 cycle after the deciding input.
// Backpressure: waits on the controller END handshake; start while busy is dropped.
//
// Ports: sys_clk, sys_rst (sync, active high), start pulse; i2c_end/i2c_ack from
// the controller (asynchronous, synchronized here); i2c_data/i2c_go to the
// controller; busy, done, err, cfg_index status.
// Optional: define I2C_CFG_RETRY_EN to retry NACKed entries up to MAX_RETRY times.
module i2c_cfg_sequencer
    import i2c_cfg_pkg::*;
#(
    parameter logic [7:0]  SLAVE_ADDR     = 8'h34,
    parameter int          LUT_SIZE       = DEF_LUT_SIZE,
    parameter logic [15:0] SETTLE_CYCLES  = 16'd5000,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd2_000_000,
    parameter int          MAX_RETRY      = 3
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    input  logic        i2c_end,
    input  logic        i2c_ack,
    output logic [23:0] i2c_data,
    output logic        i2c_go,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [5:0]  cfg_index
);

    if (LUT_SIZE < 1 || LUT_SIZE > 64) begin : g_bad_lut_size
        $error("i2c_cfg_sequencer: LUT_SIZE must be 1..64");
    end
    if (MAX_RETRY < 0 || MAX_RETRY > 15) begin : g_bad_max_retry
        $error("i2c_cfg_sequencer: MAX_RETRY must be 0..15");
    end

    localparam logic [5:0] LAST_IDX = 6'(LUT_SIZE - 1);

    cfg_state_t  state;
    cfg_entry_t  rom_entry;
    logic [23:0] tmo_cnt;
    logic [15:0] settle_cnt;
    logic        end_meta, end_sync;
    logic        ack_meta, ack_sync;
    logic        tmo_hit;
    logic        settle_last;
    logic [23:0] tmo_next;
`ifdef I2C_CFG_RETRY_EN
    logic [3:0]  retry_cnt;
`endif

    i2c_cfg_rom u_rom (
        .index (cfg_index),
        .entry (rom_entry)
    );

    // Controller flags come from a divided clock domain
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            end_meta <= 1'b0;
            end_sync <= 1'b0;
            ack_meta <= 1'b0;
            ack_sync <= 1'b0;
        end else begin
            end_meta <= i2c_end;
            end_sync <= end_meta;
            ack_meta <= i2c_ack;
            ack_sync <= ack_meta;
        end
    end

    assign tmo_hit     = (tmo_cnt >= TIMEOUT_CYCLES);
    assign tmo_next    = (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + 24'd1;
    // SETTLE always lasts at least one cycle, even with SETTLE_CYCLES of 0
    assign settle_last = ({1'b0, settle_cnt} + 17'd1) >= {1'b0, SETTLE_CYCLES};

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            i2c_data   <= '0;
            i2c_go     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            cfg_index  <= '0;
            tmo_cnt    <= '0;
            settle_cnt <= '0;
`ifdef I2C_CFG_RETRY_EN
            retry_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE, FAIL: begin
                    if (start) begin
                        state     <= LOAD;
                        cfg_index <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        err       <= 1'b0;
`ifdef I2C_CFG_RETRY_EN
                        retry_cnt <= '0;
`endif
                    end
                end
                LOAD: begin
                    i2c_data <= {SLAVE_ADDR, rom_entry};
                    tmo_cnt  <= '0;
                    i2c_go   <= 1'b1;
                    state    <= REQ;
                end
                REQ: begin
                    // END falling is the controller's acknowledgement of GO
                    if (!end_sync) begin
                        i2c_go  <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= XFER;
                    end else if (tmo_hit) begin
                        i2c_go <= 1'b0;
                        busy   <= 1'b0;
                        err    <= 1'b1;
                        state  <= FAIL;
                    end else begin
                        tmo_cnt <= tmo_next;
                    end
                end
                XFER: begin
                    if (end_sync) begin
                        state <= CHECK;
                    end else if (tmo_hit) begin
                        busy  <= 1'b0;
                        err   <= 1'b1;
                        state <= FAIL;
                    end else begin
                        tmo_cnt <= tmo_next;
                    end
                end
                CHECK: begin
                    if (!ack_sync) begin
`ifdef I2C_CFG_RETRY_EN
                        retry_cnt <= '0;
`endif
                        if (cfg_index == LAST_IDX) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            cfg_index  <= cfg_index + 6'd1;
                            settle_cnt <= '0;
                            state      <= SETTLE;
                        end
                    end else begin
`ifdef I2C_CFG_RETRY_EN
                        // Same cfg_index goes round again through SETTLE/LOAD
                        if (retry_cnt < 4'(MAX_RETRY)) begin
                            retry_cnt  <= retry_cnt + 4'd1;
                            settle_cnt <= '0;
                            state      <= SETTLE;
                        end else begin
                            busy  <= 1'b0;
                            err   <= 1'b1;
                            state <= FAIL;
                        end
`else
                        busy  <= 1'b0;
                        err   <= 1'b1;
                        state <= FAIL;
`endif
                    end
                end
                SETTLE: begin
                    if (settle_last) begin
                        state <= LOAD;
                    end else begin
                        settle_cnt <= settle_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
module tb_i2c_cfg_sequencer;

    localparam logic [7:0] SA = 8'h34;
    localparam int         N  = 11;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        start   = 1'b0;
    logic        i2c_end;
    logic        i2c_ack;
    logic [23:0] i2c_data;
    logic        i2c_go;
    logic        busy;
    logic        done;
    logic        err;
    logic [5:0]  cfg_index;

    always #10 sys_clk = ~sys_clk;

    i2c_cfg_sequencer #(
        .SLAVE_ADDR     (8'h34),
        .LUT_SIZE       (11),
        .SETTLE_CYCLES  (16'd10),
        .TIMEOUT_CYCLES (24'd100),
        .MAX_RETRY      (3)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .start     (start),
        .i2c_end   (i2c_end),
        .i2c_ack   (i2c_ack),
        .i2c_data  (i2c_data),
        .i2c_go    (i2c_go),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cfg_index (cfg_index)
    );

    // WM8731 init words {reg[6:0], val[8:0]}, hand-packed
    logic [15:0] tbl [0:N-1] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                                 16'h0812, 16'h0A00, 16'h0C00, 16'h0E01, 16'h1000,
                                 16'h1201};

    logic [23:0] exp_q [$];
    int vectors   = 0;
    int errors    = 0;
    int go_count  = 0;
    bit dead      = 1'b0;
    bit nack_en   = 1'b0;
    int nack_idx  = 0;
    int nack_left = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_entry(input int idx);
        exp_q.push_back({SA, tbl[idx]});
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) push_entry(i);
    endtask

    task automatic pulse_start();
        @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        int n = 0;
        while (busy && n < max_cyc) begin
            @(negedge sys_clk);
            n++;
        end
        if (busy) check({name, "_idle_timeout"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_go_count(input int target, input int max_cyc);
        int n = 0;
        while (go_count < target && n < max_cyc) begin
            @(negedge sys_clk);
            n++;
        end
        if (go_count < target) check("go_count_timeout", 32'(go_count), 32'(target));
    endtask

    task automatic wait_end(input logic lvl, input int max_cyc);
        int n = 0;
        while (i2c_end !== lvl && n < max_cyc) begin
            @(negedge sys_clk);
            n++;
        end
        if (i2c_end !== lvl) check("end_wait_timeout", 32'(i2c_end), 32'(lvl));
    endtask

    task automatic check_final(input string name, input logic d, input logic e,
                               input int idx, input int gos);
        check({name, "_busy"},  32'(busy), 32'd0);
        check({name, "_done"},  32'(done), 32'(d));
        check({name, "_err"},   32'(err),  32'(e));
        check({name, "_index"}, 32'(cfg_index), 32'(idx));
        check({name, "_gos"},   32'(go_count),  32'(gos));
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Controller model and scoreboard monitor: each GO rising edge is one
    // transaction whose word is compared with the head of the expected queue.
    initial begin : ctrl_model
        bit go_prev;
        bit nack;
        logic [23:0] e;
        go_prev = 1'b0;
        i2c_end = 1'b1;
        i2c_ack = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (i2c_go && !go_prev) begin
                go_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_go", i2c_data, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("i2c_data", 32'(i2c_data), 32'(e));
                end
                if (!dead) begin
                    nack = nack_en && (i2c_data[15:0] == tbl[nack_idx]) && (nack_left != 0);
                    if (nack && nack_left > 0) nack_left--;
                    repeat (2) @(negedge sys_clk);
                    i2c_end = 1'b0;
                    i2c_ack = 1'b0;
                    repeat (5) @(negedge sys_clk);
                    i2c_ack = nack;
                    i2c_end = 1'b1;
                end
            end
            go_prev = i2c_go;
        end
    end

    initial begin : stim
        int lat;

        // Reset state
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("rst_data",  32'(i2c_data), 32'd0);
        check("rst_go",    32'(i2c_go),   32'd0);
        check("rst_busy",  32'(busy),     32'd0);
        check("rst_done",  32'(done),     32'd0);
        check("rst_err",   32'(err),      32'd0);
        check("rst_index", 32'(cfg_index), 32'd0);
        repeat (3) @(negedge sys_clk);

        // Full sequence, all ACK; a start while busy must be ignored
        go_count = 0;
        push_range(0, N - 1);
        pulse_start();
        check("run1_busy", 32'(busy), 32'd1);
        wait_go_count(3, 500);
        pulse_start();
        check("run1_busy_after_ignored_start", 32'(busy), 32'd1);
        wait_idle("run1", 3000);
        check_final("run1", 1'b1, 1'b0, 10, 11);

        // Restart after DONE
        go_count = 0;
        push_range(0, N - 1);
        pulse_start();
        check("run2_done_cleared", 32'(done), 32'd0);
        wait_idle("run2", 3000);
        check_final("run2", 1'b1, 1'b0, 10, 11);

`ifdef I2C_CFG_RETRY_EN
        // Entry 2 NACKs twice then ACKs
        go_count  = 0;
        nack_en   = 1'b1;
        nack_idx  = 2;
        nack_left = 2;
        push_range(0, 2);
        push_entry(2);
        push_entry(2);
        push_range(3, N - 1);
        pulse_start();
        wait_idle("retry_ok", 4000);
        check_final("retry_ok", 1'b1, 1'b0, 10, 13);

        // Entry 3 always NACKs: 4 attempts then FAIL
        go_count  = 0;
        nack_idx  = 3;
        nack_left = -1;
        push_range(0, 3);
        push_entry(3);
        push_entry(3);
        push_entry(3);
        pulse_start();
        wait_idle("retry_fail", 3000);
        check_final("retry_fail", 1'b0, 1'b1, 3, 7);
        nack_en = 1'b0;
`else
        // Entry 3 NACKs: first NACK is fatal
        go_count  = 0;
        nack_en   = 1'b1;
        nack_idx  = 3;
        nack_left = -1;
        push_range(0, 3);
        pulse_start();
        wait_idle("nack3", 3000);
        check_final("nack3", 1'b0, 1'b1, 3, 4);
        nack_en = 1'b0;
`endif

        // Dead controller: END stuck high -> REQ timeout
        go_count = 0;
        dead     = 1'b1;
        push_entry(0);
        pulse_start();
        lat = 0;
        while (!i2c_go && lat < 50) begin
            @(negedge sys_clk);
            lat++;
        end
        check("tmo_go_seen", 32'(i2c_go), 32'd1);
        lat = 0;
        while (!err && lat < 200) begin
            @(negedge sys_clk);
            lat++;
        end
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_latency_le_103", 32'(lat <= 103), 32'd1);
        check("tmo_latency_ge_100", 32'(lat >= 100), 32'd1);
        check("tmo_go_low", 32'(i2c_go), 32'd0);
        check_final("tmo", 1'b0, 1'b1, 0, 1);
        dead = 1'b0;

        // Reset in the middle of entry 5's transfer
        go_count = 0;
        push_range(0, N - 1);
        pulse_start();
        wait_go_count(6, 1000);
        wait_end(1'b0, 20);
        repeat (3) @(negedge sys_clk);
        check("mid_index", 32'(cfg_index), 32'd5);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        check("mrst_data",  32'(i2c_data), 32'd0);
        check("mrst_go",    32'(i2c_go),   32'd0);
        check("mrst_busy",  32'(busy),     32'd0);
        check("mrst_done",  32'(done),     32'd0);
        check("mrst_err",   32'(err),      32'd0);
        check("mrst_index", 32'(cfg_index), 32'd0);
        exp_q.delete();
        wait_end(1'b1, 20);
        repeat (3) @(negedge sys_clk);
        go_count = 0;
        push_range(0, N - 1);
        pulse_start();
        wait_idle("after_rst", 3000);
        check_final("after_rst", 1'b1, 1'b0, 10, 11);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
